// File: rtl/call_frame_ctrl_pkg.sv
// Shared codes for the call-frame controller: command, error, operand-stack op/status
// encodings and the sequencer state type.
package call_frame_ctrl_pkg;

    localparam logic [1:0] CMD_NONE   = 2'd0;
    localparam logic [1:0] CMD_CALL   = 2'd1;
    localparam logic [1:0] CMD_RETURN = 2'd2;

    localparam logic [2:0] ERR_NONE            = 3'd0;
    localparam logic [2:0] ERR_FRAME_OVERFLOW  = 3'd1;
    localparam logic [2:0] ERR_ARG_UNDERFLOW   = 3'd2;
    localparam logic [2:0] ERR_FRAME_UNDERFLOW = 3'd3;
    localparam logic [2:0] ERR_RESULT_MISSING  = 3'd4;
    localparam logic [2:0] ERR_STACK           = 3'd5;

    // Operand-stack interface encodings (SuperStack op and status codes)
    localparam logic [2:0] STK_OP_NONE                 = 3'd0;
    localparam logic [2:0] STK_OP_INDEX_RESET          = 3'd4;
    localparam logic [2:0] STK_OP_INDEX_RESET_AND_PUSH = 3'd5;

    localparam logic [2:0] STK_ST_OK        = 3'd0;
    localparam logic [2:0] STK_ST_OVERFLOW  = 3'd1;
    localparam logic [2:0] STK_ST_UNDERFLOW = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        CALL_DONE,
        RET_CAPTURE,
        RET_REWIND,
        RET_DONE
    } state_t;

endpackage

// File: rtl/frame_lifo.sv
// Register-file LIFO holding saved call frames; dout is always the top entry.
module frame_lifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int N = 1 << AW;
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [DW-1:0] mem [N];
    logic [AW-1:0] top_idx;

    assign top_idx = AW'(count - ONE);
    assign full    = (count == (AW+1)'(N));
    assign empty   = (count == '0);
    assign dout    = mem[top_idx];

    always_ff @(posedge clk) begin
        if (push && !full) mem[count[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + ONE;
        end else if (pop && !empty) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/call_frame_ctrl.sv
// Call/return sequencer: saves {frame base, return pc} on CALL, rewinds the operand
// stack to the frame base (optionally re-pushing one result) on RETURN.
module call_frame_ctrl
    import call_frame_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 1,
    parameter int FRAMES   = 2,
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          cmd,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [DEPTH:0]      arg_count,
    input  logic                result_count,
    input  logic [PC_WIDTH-1:0] return_pc,
    output logic                done,
    output logic [2:0]          error,
    output logic [PC_WIDTH-1:0] resume_pc,
    output logic [FRAMES:0]     frame_depth,
    output logic [2:0]          stk_op,
    output logic [WIDTH-1:0]    stk_data,
    output logic [DEPTH:0]      stk_new_index,
    output logic [DEPTH:0]      stk_underflow_limit,
    input  logic [DEPTH:0]      stk_index,
    input  logic [WIDTH-1:0]    stk_out,
    input  logic [2:0]          stk_status
);

    localparam int FW = DEPTH + 1 + PC_WIDTH;

    state_t              state, next_state;
    logic [DEPTH:0]      limit;
    logic [2:0]          err_r, call_err, ret_err;
    logic                rc_r, arg_short, stack_fault;
    logic [WIDTH-1:0]    result_r;
    logic [PC_WIDTH-1:0] resume_pc_r;
    logic                push, pop, full, empty, accept_call, accept_ret;
    logic [FW-1:0]       top_frame;

    frame_lifo #(.DW(FW), .AW(FRAMES)) u_frames (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   ({limit, return_pc}),
        .dout  (top_frame),
        .full  (full),
        .empty (empty),
        .count (frame_depth)
    );

    assign stk_underflow_limit = limit;
    assign resume_pc           = resume_pc_r;

    // Argument check is an addition so a limit above the index cannot wrap.
    always_comb begin
        arg_short   = ({1'b0, arg_count} + {1'b0, limit}) > {1'b0, stk_index};
        stack_fault = (stk_status == STK_ST_OVERFLOW) || (stk_status == STK_ST_UNDERFLOW);
        if (full)           call_err = ERR_FRAME_OVERFLOW;
        else if (arg_short) call_err = ERR_ARG_UNDERFLOW;
        else                call_err = ERR_NONE;
        if (empty)                                      ret_err = ERR_FRAME_UNDERFLOW;
        else if (result_count && (stk_index == limit))  ret_err = ERR_RESULT_MISSING;
        else                                            ret_err = ERR_NONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        cmd_ready     = 1'b0;
        done          = 1'b0;
        error         = ERR_NONE;
        push          = 1'b0;
        pop           = 1'b0;
        accept_call   = 1'b0;
        accept_ret    = 1'b0;
        stk_op        = STK_OP_NONE;
        stk_data      = '0;
        stk_new_index = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd == CMD_CALL) begin
                    accept_call = 1'b1;
                    push        = (call_err == ERR_NONE);
                    next_state  = CALL_DONE;
                end else if (cmd_valid && cmd == CMD_RETURN) begin
                    accept_ret = 1'b1;
                    next_state = (ret_err == ERR_NONE) ? RET_CAPTURE : RET_DONE;
                end
            end
            CALL_DONE: begin
                done       = 1'b1;
                error      = err_r;
                next_state = IDLE;
            end
            RET_CAPTURE: next_state = RET_REWIND;
            RET_REWIND: begin
                stk_new_index = limit;
                if (rc_r) begin
                    stk_op   = STK_OP_INDEX_RESET_AND_PUSH;
                    stk_data = result_r;
                end else begin
                    stk_op = STK_OP_INDEX_RESET;
                end
                // Pop commits on the edge into RET_DONE so done, resume_pc,
                // limit and frame_depth are all visible together.
                pop        = 1'b1;
                next_state = RET_DONE;
            end
            RET_DONE: begin
                done       = 1'b1;
                error      = (err_r == ERR_NONE && stack_fault) ? ERR_STACK : err_r;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            limit       <= '0;
            err_r       <= ERR_NONE;
            rc_r        <= 1'b0;
            result_r    <= '0;
            resume_pc_r <= '0;
        end else begin
            if (accept_call) err_r <= call_err;
            if (push)        limit <= stk_index - arg_count;
            if (accept_ret) begin
                err_r <= ret_err;
                rc_r  <= result_count;
            end
            if (state == RET_CAPTURE) result_r <= stk_out;
            if (pop) begin
                limit       <= top_frame[FW-1:PC_WIDTH];
                resume_pc_r <= top_frame[PC_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_call_frame_ctrl.sv
// Directed bench for call_frame_ctrl: table of CALL/RETURN vectors plus hand-written
// busy-ignore, CMD_NONE and reset-during-rewind sequences.
module tb_call_frame_ctrl;
    import call_frame_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] cmd = CMD_NONE;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] arg_count = '0;
    logic       result_count = 1'b0;
    logic [7:0] return_pc = '0;
    logic       done;
    logic [2:0] error;
    logic [7:0] resume_pc;
    logic [2:0] frame_depth;
    logic [2:0] stk_op;
    logic [7:0] stk_data;
    logic [3:0] stk_new_index;
    logic [3:0] stk_underflow_limit;
    logic [3:0] stk_index = '0;
    logic [7:0] stk_out = '0;
    logic [2:0] stk_status = STK_ST_OK;

    int checks = 0;
    int failures = 0;

    call_frame_ctrl #(.WIDTH(8), .DEPTH(3), .FRAMES(2), .PC_WIDTH(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd                 (cmd),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .arg_count           (arg_count),
        .result_count        (result_count),
        .return_pc           (return_pc),
        .done                (done),
        .error               (error),
        .resume_pc           (resume_pc),
        .frame_depth         (frame_depth),
        .stk_op              (stk_op),
        .stk_data            (stk_data),
        .stk_new_index       (stk_new_index),
        .stk_underflow_limit (stk_underflow_limit),
        .stk_index           (stk_index),
        .stk_out             (stk_out),
        .stk_status          (stk_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic [3:0] arg;
        logic       rc;
        logic [7:0] pc;
        logic [3:0] idx;
        logic [7:0] out;
        logic [2:0] status;
        logic [2:0] e_err;
        int         e_lat;
        logic [2:0] e_op;
        logic [3:0] e_nidx;
        logic [7:0] e_data;
        logic [7:0] e_pc;
        logic [3:0] e_limit;
        logic [2:0] e_depth;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input int n);
        int lat;
        int op_n;
        logic [2:0] op_v;
        logic [3:0] nidx_v;
        logic [7:0] data_v;
        lat = 0; op_n = 0; op_v = '0; nidx_v = '0; data_v = '0;
        @(negedge clk);
        cmd = t.cmd; arg_count = t.arg; result_count = t.rc; return_pc = t.pc;
        stk_index = t.idx; stk_out = t.out; stk_status = t.status; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd = CMD_NONE;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk($sformatf("v%0d_busy_ready", n), cmd_ready, 0);
            if (stk_op != STK_OP_NONE) begin
                op_n++; op_v = stk_op; nidx_v = stk_new_index; data_v = stk_data;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        chk($sformatf("v%0d_latency", n), lat, t.e_lat);
        chk($sformatf("v%0d_error", n), error, t.e_err);
        chk($sformatf("v%0d_limit", n), stk_underflow_limit, t.e_limit);
        chk($sformatf("v%0d_depth", n), frame_depth, t.e_depth);
        if (t.e_lat == 3) chk($sformatf("v%0d_resume_pc", n), resume_pc, t.e_pc);
        if (t.e_op == STK_OP_NONE) begin
            chk($sformatf("v%0d_no_stack_op", n), op_n, 0);
        end else begin
            chk($sformatf("v%0d_op_cycles", n), op_n, 1);
            chk($sformatf("v%0d_stk_op", n), op_v, t.e_op);
            chk($sformatf("v%0d_new_index", n), nidx_v, t.e_nidx);
            if (t.e_op == STK_OP_INDEX_RESET_AND_PUSH)
                chk($sformatf("v%0d_stk_data", n), data_v, t.e_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int stray;
        vec_t v;
        //        cmd         arg    rc    pc     idx    out    status            err                  lat op                           nidx   data   rpc    lim    dep
        vecs[0]  = '{CMD_CALL,   4'd2,  1'b0, 8'h40, 4'd5,  8'h00, STK_ST_OK,        ERR_NONE,            1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd3, 3'd1};
        vecs[1]  = '{CMD_RETURN, 4'd0,  1'b1, 8'h00, 4'd7,  8'h2A, STK_ST_OK,        ERR_NONE,            3, STK_OP_INDEX_RESET_AND_PUSH, 4'd3, 8'h2A, 8'h40, 4'd0, 3'd0};
        vecs[2]  = '{CMD_CALL,   4'd6,  1'b0, 8'h00, 4'd5,  8'h00, STK_ST_OK,        ERR_ARG_UNDERFLOW,   1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd0, 3'd0};
        vecs[3]  = '{CMD_RETURN, 4'd0,  1'b0, 8'h00, 4'd5,  8'h00, STK_ST_OK,        ERR_FRAME_UNDERFLOW, 1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd0, 3'd0};
        vecs[4]  = '{CMD_CALL,   4'd1,  1'b0, 8'h11, 4'd4,  8'h00, STK_ST_OK,        ERR_NONE,            1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd3, 3'd1};
        vecs[5]  = '{CMD_CALL,   4'd0,  1'b0, 8'h22, 4'd6,  8'h00, STK_ST_OK,        ERR_NONE,            1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd6, 3'd2};
        vecs[6]  = '{CMD_CALL,   4'd2,  1'b0, 8'h33, 4'd9,  8'h00, STK_ST_OK,        ERR_NONE,            1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd7, 3'd3};
        vecs[7]  = '{CMD_RETURN, 4'd0,  1'b1, 8'h00, 4'd7,  8'h00, STK_ST_OK,        ERR_RESULT_MISSING,  1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd7, 3'd3};
        vecs[8]  = '{CMD_CALL,   4'd3,  1'b0, 8'h44, 4'd10, 8'h00, STK_ST_OK,        ERR_NONE,            1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd7, 3'd4};
        vecs[9]  = '{CMD_CALL,   4'd15, 1'b0, 8'h55, 4'd2,  8'h00, STK_ST_OK,        ERR_FRAME_OVERFLOW,  1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd7, 3'd4};
        vecs[10] = '{CMD_RETURN, 4'd0,  1'b0, 8'h00, 4'd12, 8'h00, STK_ST_OK,        ERR_NONE,            3, STK_OP_INDEX_RESET,          4'd7, 8'h00, 8'h44, 4'd7, 3'd3};
        vecs[11] = '{CMD_RETURN, 4'd0,  1'b1, 8'h00, 4'd9,  8'h5C, STK_ST_OVERFLOW,  ERR_STACK,           3, STK_OP_INDEX_RESET_AND_PUSH, 4'd7, 8'h5C, 8'h33, 4'd6, 3'd2};
        vecs[12] = '{CMD_RETURN, 4'd0,  1'b0, 8'h00, 4'd6,  8'h00, STK_ST_UNDERFLOW, ERR_STACK,           3, STK_OP_INDEX_RESET,          4'd6, 8'h00, 8'h22, 4'd3, 3'd1};
        vecs[13] = '{CMD_RETURN, 4'd0,  1'b1, 8'h00, 4'd4,  8'h99, STK_ST_OK,        ERR_NONE,            3, STK_OP_INDEX_RESET_AND_PUSH, 4'd3, 8'h99, 8'h11, 4'd0, 3'd0};
        vecs[14] = '{CMD_RETURN, 4'd0,  1'b0, 8'h00, 4'd4,  8'h00, STK_ST_OK,        ERR_FRAME_UNDERFLOW, 1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd0, 3'd0};
        vecs[15] = '{CMD_CALL,   4'd0,  1'b0, 8'h10, 4'd2,  8'h00, STK_ST_OK,        ERR_NONE,            1, STK_OP_NONE,                 4'd0, 8'h00, 8'h00, 4'd2, 3'd1};

        // Clock/reset
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_limit", stk_underflow_limit, 0);
        chk("rst_depth", frame_depth, 0);
        chk("rst_stk_op", stk_op, STK_OP_NONE);
        chk("rst_done", done, 0);
        chk("rst_error", error, ERR_NONE);
        chk("rst_resume_pc", resume_pc, 0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // RETURN while a CALL is held on cmd_valid through the busy cycles
        @(negedge clk);
        cmd = CMD_RETURN; result_count = 1'b0; stk_index = 4'd5; stk_status = STK_ST_OK;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd = CMD_CALL; arg_count = 4'd0; return_pc = 8'hEE;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        cmd_valid = 1'b0; cmd = CMD_NONE;
        chk("busy_latency", lat, 3);
        chk("busy_resume_pc", resume_pc, 8'h10);
        chk("busy_limit", stk_underflow_limit, 0);
        @(negedge clk);
        chk("busy_ready_after", cmd_ready, 1);
        chk("busy_depth_after", frame_depth, 0);

        // CMD_NONE with cmd_valid is not a command
        cmd = CMD_NONE; cmd_valid = 1'b1;
        @(negedge clk);
        chk("none_ready", cmd_ready, 1);
        chk("none_done", done, 0);
        cmd_valid = 1'b0;

        // Reset asserted while the rewind op is on the bus
        v = '{CMD_CALL, 4'd1, 1'b0, 8'h77, 4'd4, 8'h00, STK_ST_OK, ERR_NONE, 1,
              STK_OP_NONE, 4'd0, 8'h00, 8'h00, 4'd3, 3'd1};
        run_vec(v, 16);
        @(negedge clk);
        cmd = CMD_RETURN; result_count = 1'b1; stk_index = 4'd6; stk_out = 8'h3C; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd = CMD_NONE;
        @(negedge clk);
        @(negedge clk);
        chk("rr_rewind_op", stk_op, STK_OP_INDEX_RESET_AND_PUSH);
        #2 reset = 1'b0;
        #1;
        chk("rr_stk_op", stk_op, STK_OP_NONE);
        chk("rr_limit", stk_underflow_limit, 0);
        chk("rr_cmd_ready", cmd_ready, 1);
        chk("rr_depth", frame_depth, 0);
        chk("rr_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (stk_op != STK_OP_NONE || done) stray++;
        end
        chk("rr_no_stray_activity", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/call_frame_ctrl.md
CALL_FRAME_CTRL -- requirements
Module: call_frame_ctrl

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand-stack data width.
REQ-002 Parameter DEPTH SHALL default to 1; stack index and limit fields are DEPTH+1 bits wide.
REQ-003 Parameter FRAMES SHALL default to 2 and set frame-stack capacity to 2^FRAMES entries.
REQ-004 Parameter PC_WIDTH SHALL default to 8 and set the return-address width.
REQ-005 Ports SHALL be exactly:
- clk  in  1  clock; the single clock for the block
- reset  in  1  reset; asynchronous, active-low
- cmd  in  2  `CMD_NONE / `CMD_CALL / `CMD_RETURN
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- arg_count  in  DEPTH+1  CALL argument count
- result_count  in  1  RETURN result count, 0 or 1
- return_pc  in  PC_WIDTH  CALL return address
- done  out  1  one-cycle completion pulse
- error  out  3  error code, valid with done
- resume_pc  out  PC_WIDTH  popped return address, valid with done on RETURN
- frame_depth  out  FRAMES+1  live frame count
- stk_op  out  3  operand-stack op, SuperStack.vh encoding
- stk_data  out  WIDTH  operand-stack push data
- stk_new_index  out  DEPTH+1  operand-stack new index
- stk_underflow_limit  out  DEPTH+1  current frame base
- stk_index  in  DEPTH+1  operand-stack index
- stk_out  in  WIDTH  operand-stack top of stack
- stk_status  in  3  operand-stack status

Function
REQ-006 A command SHALL be accepted on a rising clk edge with cmd_valid=1, cmd_ready=1 and cmd other than `CMD_NONE; cmd_valid while busy SHALL be ignored.
REQ-007 States SHALL be IDLE, CALL_DONE, RET_CAPTURE, RET_REWIND, RET_DONE.
REQ-008 CALL accept SHALL check frame_depth==2^FRAMES first (`ERR_FRAME_OVERFLOW), then arg_count > stk_index-stk_underflow_limit (`ERR_ARG_UNDERFLOW), comparing before any subtraction.
REQ-009 CALL without error SHALL push {stk_underflow_limit, return_pc} onto the frame stack, set stk_underflow_limit=stk_index-arg_count, and increment frame_depth, all on the accept edge.
REQ-010 CALL SHALL move to CALL_DONE, pulse done with error, and return to IDLE; on error, limit and frame_depth SHALL remain unchanged.
REQ-011 RETURN accept with frame_depth==0 SHALL give `ERR_FRAME_UNDERFLOW via RET_DONE with no stack op.
REQ-012 RETURN accept with result_count=1 and stk_index==stk_underflow_limit SHALL give `ERR_RESULT_MISSING via RET_DONE with no stack op.
REQ-013 RET_CAPTURE SHALL register stk_out into an internal result register.
REQ-014 RET_REWIND SHALL drive stk_new_index=stk_underflow_limit for exactly one cycle, with:
- stk_op=`INDEX_RESET_AND_PUSH and stk_data=result when result_count=1
- stk_op=`INDEX_RESET when result_count=0
REQ-015 RET_DONE SHALL pop the frame stack, restore stk_underflow_limit, set resume_pc, decrement frame_depth, and pulse done.
REQ-016 stk_op SHALL be `NONE in every state except RET_REWIND.
REQ-017 Latency SHALL be:
- CALL: done 1 cycle after accept
- successful RETURN: done 3 cycles after accept
- error RETURN: done 1 cycle after accept
REQ-018 RET_DONE SHALL report a stk_status of `OVERFLOW or `UNDERFLOW as `ERR_STACK and still complete the pop.

Reset
REQ-019 reset low SHALL immediately force:
- state IDLE, cmd_ready=1, done=0
- error=`ERR_NONE, resume_pc=0, frame_depth=0
- stk_op=`NONE, stk_data=0, stk_new_index=0, stk_underflow_limit=0
REQ-020 Reset mid-sequence SHALL abandon the sequence without any further stack op.

Structure
REQ-021 Shared header call_frame_ctrl.vh SHALL hold the `CMD_* and `ERR_* (`NONE, `FRAME_OVERFLOW, `ARG_UNDERFLOW, `FRAME_UNDERFLOW, `RESULT_MISSING, `STACK) defines; stack op codes SHALL come from SuperStack.vh.
REQ-022 The frame stack SHALL be one sub-module, frame_lifo: a register-file LIFO with push, pop, full and empty.

Verification (WIDTH=8, DEPTH=3, FRAMES=2, PC_WIDTH=8)
REQ-023 Release reset -> cmd_ready=1, stk_underflow_limit=0, frame_depth=0, stk_op=`NONE.
REQ-024 stk_index=5, CALL arg_count=2, return_pc=0x40 -> next cycle done=1, error=`ERR_NONE, stk_underflow_limit=3, frame_depth=1.
REQ-025 Then stk_index=7, stk_out=0x2A, RETURN result_count=1 -> accept+2: stk_op=`INDEX_RESET_AND_PUSH, stk_new_index=3, stk_data=0x2A; accept+3: done, resume_pc=0x40, limit=0, frame_depth=0.
REQ-026 stk_index=5, limit=0, CALL arg_count=6 -> `ERR_ARG_UNDERFLOW; limit and depth unchanged.
REQ-027 Four CALLs, then a fifth -> `ERR_FRAME_OVERFLOW; five RETURNs -> fifth reports `ERR_FRAME_UNDERFLOW.
REQ-028 reset low during RET_REWIND -> same cycle stk_op=`NONE, limit=0, cmd_ready=1.
